// File: rtl/ps2_note_decoder.sv
// ps2_note_decoder: PS/2 set-2 frame receiver tracking held piano keys (C..B) as a 12-bit mask.
module ps2_note_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        clk_kb,
  input  logic        data_kb,
  output logic [7:0]  out_reg,
  output logic        oByteValid,
  output logic [11:0] oNoteMask,
  output logic [3:0]  oLastNote,
  output logic        oFrameError
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [2:0] clk_sync_q, clk_sync_d;
  logic [1:0] dat_sync_q, dat_sync_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, out_reg_q, out_reg_d;
  logic par_ok_q, par_ok_d, valid_q, valid_d, err_q, err_d, ext_q, ext_d, brk_q, brk_d;
  logic [11:0] mask_q, mask_d;
  logic [3:0] last_q, last_d, note;
  logic [CW-1:0] tmo_q, tmo_d;
  logic fall, bit_in, accept, hit, timeout;
  always_comb begin
    hit = 1'b1;
    note = 4'd0;
    case (shift_q)
      8'h1C: note = 4'd0;
      8'h1D: note = 4'd1;
      8'h1B: note = 4'd2;
      8'h24: note = 4'd3;
      8'h23: note = 4'd4;
      8'h2B: note = 4'd5;
      8'h2C: note = 4'd6;
      8'h34: note = 4'd7;
      8'h35: note = 4'd8;
      8'h33: note = 4'd9;
      8'h3C: note = 4'd10;
      8'h3B: note = 4'd11;
      default: hit = 1'b0;
    endcase
  end
  // clk_sync_q[2] is the previous synchronised clk_kb, used for edge detection
  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], clk_kb};
    dat_sync_d = {dat_sync_q[0], data_kb};
    fall = clk_sync_q[2] & ~clk_sync_q[1];
    bit_in = dat_sync_q[1];
    timeout = state_q != IDLE && !fall && tmo_q == CW'(TIMEOUT_CYCLES - 1);
    tmo_d = (fall || timeout || state_q == IDLE) ? '0 : tmo_q + 1'b1;
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;
    par_ok_d = par_ok_q;
    err_d = 1'b0;
    accept = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      err_d = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          err_d = bit_in;
          state_d = bit_in ? IDLE : DATA;
          bit_cnt_d = 3'd0;
        end
        DATA: begin
          shift_d = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d = bit_cnt_q == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par_ok_d = ^{shift_q, bit_in};
          state_d = STOP;
        end
        default: begin
          accept = bit_in & par_ok_q;
          err_d = ~(bit_in & par_ok_q);
          state_d = IDLE;
        end
      endcase
    end
  end
  // Prefix bytes only touch flags; any other accepted byte consumes and clears them
  always_comb begin
    out_reg_d = accept ? shift_q : out_reg_q;
    valid_d = accept;
    ext_d = ext_q;
    brk_d = brk_q;
    mask_d = mask_q;
    last_d = last_q;
    if (accept) begin
      if (shift_q == 8'hE0) ext_d = 1'b1;
      else if (shift_q == 8'hF0) brk_d = 1'b1;
      else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!ext_q && hit) begin
          mask_d[note] = ~brk_q;
          last_d = brk_q ? last_q : note;
        end
      end
    end
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      bit_cnt_q <= '0;
      shift_q <= '0;
      out_reg_q <= '0;
      par_ok_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      mask_q <= '0;
      last_q <= '0;
      tmo_q <= '0;
    end else begin
      state_q <= state_d;
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      out_reg_q <= out_reg_d;
      par_ok_q <= par_ok_d;
      valid_q <= valid_d;
      err_q <= err_d;
      ext_q <= ext_d;
      brk_q <= brk_d;
      mask_q <= mask_d;
      last_q <= last_d;
      tmo_q <= tmo_d;
    end
  end
  assign out_reg = out_reg_q;
  assign oByteValid = valid_q;
  assign oNoteMask = mask_q;
  assign oLastNote = last_q;
  assign oFrameError = err_q;
endmodule

// File: tb/tb_ps2_note_decoder.sv
// tb_ps2_note_decoder: directed PS/2 frames with hand-computed note mask expectations.
module tb_ps2_note_decoder;
  localparam int TMO = 300;
  localparam int HALF = 10;
  logic Clock = 1'b0, Reset = 1'b0, clk_kb = 1'b1, data_kb = 1'b1;
  logic [7:0] out_reg;
  logic oByteValid, oFrameError;
  logic [11:0] oNoteMask;
  logic [3:0] oLastNote;
  int n_cmp = 0, n_bad = 0, n_valid = 0, n_err = 0, v0, e0;
  ps2_note_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .Clock(Clock), .Reset(Reset), .clk_kb(clk_kb), .data_kb(data_kb),
    .out_reg(out_reg), .oByteValid(oByteValid), .oNoteMask(oNoteMask),
    .oLastNote(oLastNote), .oFrameError(oFrameError)
  );
  always #5 Clock = ~Clock;
  always @(posedge Clock) begin
    if (oByteValid) n_valid <= n_valid + 1;
    if (oFrameError) n_err <= n_err + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [10:0] frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      data_kb = f[i];
      repeat (HALF) @(negedge Clock);
      clk_kb = 1'b0;
      repeat (HALF) @(negedge Clock);
      clk_kb = 1'b1;
    end
    data_kb = 1'b1;
    repeat (5) @(negedge Clock);
  endtask
  task automatic send(input logic [7:0] b);
    send_bits(frame(b), 11);
  endtask
  task automatic do_reset();
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
  endtask
  initial begin
    do_reset();
    check("rst_out", out_reg, 0);
    check("rst_mask", oNoteMask, 0);
    check("rst_last", oLastNote, 0);
    check("rst_pulses", {oByteValid, oFrameError}, 0);
    v0 = n_valid;
    send(8'h23);
    check("t1_out", out_reg, 8'h23);
    check("t1_valid", n_valid - v0, 1);
    check("t1_mask", oNoteMask, 12'h010);
    check("t1_last", oLastNote, 4);
    do_reset();
    v0 = n_valid;
    send(8'h1C);
    check("t2_mask_c", oNoteMask, 12'h001);
    send(8'h33);
    check("t2_mask_ca", oNoteMask, 12'h201);
    check("t2_last_a", oLastNote, 9);
    send(8'hF0);
    check("t2_mask_f0", oNoteMask, 12'h201);
    send(8'h1C);
    check("t2_mask_brk", oNoteMask, 12'h200);
    check("t2_last", oLastNote, 9);
    check("t2_valid", n_valid - v0, 4);
    v0 = n_valid;
    e0 = n_err;
    send_bits(frame(8'h1B) ^ 11'h200, 11);
    check("t3_err", n_err - e0, 1);
    check("t3_novalid", n_valid - v0, 0);
    check("t3_out", out_reg, 8'h1C);
    check("t3_mask", oNoteMask, 12'h200);
    send(8'h1B);
    check("t3_mask_good", oNoteMask, 12'h204);
    check("t3_last", oLastNote, 2);
    e0 = n_err;
    send_bits(frame(8'h3B), 6);
    repeat (TMO / 2) @(negedge Clock);
    check("t4_early", n_err - e0, 0);
    repeat (TMO / 2 + 10) @(negedge Clock);
    check("t4_timeout", n_err - e0, 1);
    check("t4_mask_kept", oNoteMask, 12'h204);
    send(8'h3B);
    check("t4_out", out_reg, 8'h3B);
    check("t4_mask", oNoteMask, 12'hA04);
    check("t4_last", oLastNote, 11);
    do_reset();
    v0 = n_valid;
    e0 = n_err;
    send(8'hE0);
    send(8'h1C);
    check("t5_ext_make", oNoteMask, 0);
    send(8'hE0);
    send(8'hF0);
    send(8'h1C);
    send(8'h15);
    check("t5_mask", oNoteMask, 0);
    check("t5_valid", n_valid - v0, 6);
    check("t5_out", out_reg, 8'h15);
    check("t5_noerr", n_err - e0, 0);
    send(8'h1C);
    send(8'h34);
    send(8'h1C);
    check("t6_pre_mask", oNoteMask, 12'h081);
    check("t6_typematic_last", oLastNote, 0);
    v0 = n_valid;
    e0 = n_err;
    send_bits(frame(8'h24), 6);
    Reset = 1'b0;
    #1;
    check("t6_rst_out", out_reg, 0);
    check("t6_rst_mask", oNoteMask, 0);
    check("t6_rst_last", oLastNote, 0);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    repeat (5) @(negedge Clock);
    check("t6_nopulse", {n_valid - v0, n_err - e0}, 0);
    send(8'h24);
    check("t6_mask", oNoteMask, 12'h008);
    check("t6_last", oLastNote, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
